// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, word width
// and the address range check used on both the core and the host port.
package data_memory_responder_pkg;

  // Word width fixed by the core's main-memory interface.
  localparam int DATA_WIDTH = 16;

  // Address width on both ports before range checking.
  localparam int PORT_ADDR_WIDTH = 16;

  // Responder FSM: HOLD keeps the core in reset and gives the RAM to the host,
  // RUN hands the RAM to the core.
  localparam logic [0:0] HOLD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // True when every address bit above the implemented depth is zero.
  function automatic logic addr_in_range(input logic [PORT_ADDR_WIDTH-1:0] addr,
                                         input int unsigned addr_width);
    return ((addr >> addr_width) == '0);
  endfunction

endpackage

// File: rtl/data_memory_responder_sync_ram_1p.sv
// Single-port synchronous RAM with a registered read port. A write and a read
// to the same address at the same edge return the old contents
// (read-before-write). The read register only updates when en is high, so it
// holds its value across idle cycles. Contents are not reset.
module sync_ram_1p #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read the old word first, then write, on an enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: word-addressed RAM shared between the core (RUN) and a
// host load port (HOLD). The host preloads/reads back memory while the core is
// held in reset, and starts/stops the core with host_go / host_halt.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds its payload stable until that edge. The host
// request side is only ready in HOLD with no response outstanding; the host
// response side holds host_rsp_valid and host_rsp_data stable until retired by
// host_rsp_ready. Host writes produce no response.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = data_memory_responder_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           address_from_core,
  input  logic [DATA_WIDTH-1:0] data_from_core,
  input  logic                  data_from_core_write_en,
  output logic [DATA_WIDTH-1:0] data_to_core,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_write,
  input  logic [15:0]           host_req_addr,
  input  logic [DATA_WIDTH-1:0] host_req_wdata,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  input  logic                  host_go,
  input  logic                  host_halt,
  output logic                  core_hold,
  output logic                  addr_error,
  output logic [0:0]            dbg_state
);

  logic [0:0]            state_q, state_d;
  logic                  core_hold_q, core_hold_d;
  logic                  rsp_valid_q, rsp_valid_d;
  // Response is in the cycle right after its RAM read: data still in the RAM.
  logic                  rsp_fresh_q, rsp_fresh_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  // The previous RAM access belonged to the core: its data is in the RAM.
  logic                  sel_core_q, sel_core_d;
  logic [DATA_WIDTH-1:0] core_data_q, core_data_d;
  // The previous RAM access was out of range: force its read data to zero.
  logic                  rd_oor_q, rd_oor_d;
  logic                  addr_error_q, addr_error_d;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  host_acc;
  logic                  host_in_range;
  logic                  core_in_range;

  sync_ram_1p #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign host_in_range  = addr_in_range(host_req_addr, ADDR_WIDTH);
  assign core_in_range  = addr_in_range(address_from_core, ADDR_WIDTH);
  // Gated by reset so the host sees not-ready while reset is asserted.
  assign host_req_ready = reset & (state_q == HOLD) & ~rsp_valid_q;
  assign host_acc       = host_req_valid & host_req_ready;
  assign rd_data        = rd_oor_q ? '0 : ram_rdata;

  // Next-state, RAM port mux and response/capture bookkeeping.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    addr_error_d = addr_error_q;
    rd_oor_d     = rd_oor_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = host_req_addr[ADDR_WIDTH-1:0];
    ram_wdata    = host_req_wdata;

    if (rsp_valid_q && host_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (state_q == RUN) begin
      // The core owns the RAM and accesses it every cycle, including the
      // cycle in which host_halt arrives.
      ram_en    = 1'b1;
      ram_we    = data_from_core_write_en & core_in_range;
      ram_addr  = address_from_core[ADDR_WIDTH-1:0];
      ram_wdata = data_from_core;
      rd_oor_d  = ~core_in_range;
      if (!core_in_range) begin
        addr_error_d = 1'b1;
      end
      if (host_halt) begin
        state_d = HOLD;
      end
    end else begin
      if (host_acc) begin
        ram_en   = 1'b1;
        ram_we   = host_req_write & host_in_range;
        rd_oor_d = ~host_in_range;
        if (!host_in_range) begin
          addr_error_d = 1'b1;
        end
        if (!host_req_write) begin
          rsp_valid_d = 1'b1;
        end
      end
      // A go pulse is dropped while a response is still outstanding.
      if (host_go && !rsp_valid_q) begin
        state_d = RUN;
      end
    end

    rsp_fresh_d = host_acc & ~host_req_write;
    rsp_data_d  = rsp_fresh_q ? rd_data : rsp_data_q;
    sel_core_d  = (state_q == RUN);
    core_data_d = sel_core_q ? rd_data : core_data_q;
    core_hold_d = (state_d == HOLD);
  end

  // State and output registers; reset forces HOLD and drops any response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HOLD;
      core_hold_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_fresh_q  <= 1'b0;
      rsp_data_q   <= '0;
      sel_core_q   <= 1'b0;
      core_data_q  <= '0;
      rd_oor_q     <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_hold_q  <= core_hold_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_fresh_q  <= rsp_fresh_d;
      rsp_data_q   <= rsp_data_d;
      sel_core_q   <= sel_core_d;
      core_data_q  <= core_data_d;
      rd_oor_q     <= rd_oor_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign data_to_core   = sel_core_q ? rd_data : core_data_q;
  assign host_rsp_valid = rsp_valid_q;
  assign host_rsp_data  = rsp_fresh_q ? rd_data : rsp_data_q;
  assign core_hold      = core_hold_q;
  assign addr_error     = addr_error_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: behavioural memory model, expected-value
// queues for core loads and host read responses, and a monitor that checks
// whatever the DUT presents.
module tb_data_memory_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        reset;
  logic [15:0] address_from_core;
  logic [15:0] data_from_core;
  logic        data_from_core_write_en;
  logic [15:0] data_to_core;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_write;
  logic [15:0] host_req_addr;
  logic [15:0] host_req_wdata;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [15:0] host_rsp_data;
  logic        host_go;
  logic        host_halt;
  logic        core_hold;
  logic        addr_error;
  logic [0:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  bit rsp_rand = 1'b0;

  logic [15:0] model_mem [0:DEPTH-1];
  logic        err_exp;
  logic [15:0] core_exp_q [$];
  logic [15:0] host_exp_q [$];

  data_memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .address_from_core       (address_from_core),
    .data_from_core          (data_from_core),
    .data_from_core_write_en (data_from_core_write_en),
    .data_to_core            (data_to_core),
    .host_req_valid          (host_req_valid),
    .host_req_ready          (host_req_ready),
    .host_req_write          (host_req_write),
    .host_req_addr           (host_req_addr),
    .host_req_wdata          (host_req_wdata),
    .host_rsp_valid          (host_rsp_valid),
    .host_rsp_ready          (host_rsp_ready),
    .host_rsp_data           (host_rsp_data),
    .host_go                 (host_go),
    .host_halt               (host_halt),
    .core_hold               (core_hold),
    .addr_error              (addr_error),
    .dbg_state               (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [15:0] a);
    return a < 16'(DEPTH);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    return in_range(a) ? model_mem[a[AW-1:0]] : 16'h0000;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d);
    if (in_range(a)) model_mem[a[AW-1:0]] = d;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (core_exp_q.size() > 0) begin
        check("core_rdata", data_to_core, core_exp_q.pop_front());
      end
      if (host_rsp_valid && host_rsp_ready) begin
        if (host_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL host_rsp_unexpected actual=%h required=none", host_rsp_data);
        end else begin
          check("host_rsp_data", host_rsp_data, host_exp_q.pop_front());
        end
      end
    end
  end

  // Randomised response back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_rand) host_rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- drivers ----------------
  task automatic host_req(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    bit ok;
    host_req_valid = 1'b1;
    host_req_write = wr;
    host_req_addr  = a;
    host_req_wdata = d;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge clk);
      if (host_req_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL host_req_timeout actual=ready_low required=ready_high");
      host_req_valid = 1'b0;
    end else begin
      if (!in_range(a)) err_exp = 1'b1;
      if (wr) model_write(a, d);
      else host_exp_q.push_back(model_read(a));
    end
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
  endtask

  // Host read issued in the same cycle as a go pulse.
  task automatic host_read_with_go(input logic [15:0] a);
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = a;
    host_go        = 1'b1;
    @(negedge clk);
    check("go_req_ready", {15'd0, host_req_ready}, 16'd1);
    if (host_req_ready) host_exp_q.push_back(model_read(a));
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
    host_go        = 1'b0;
  endtask

  // One core access cycle in RUN; every cycle returns read data.
  task automatic core_cycle(input logic [15:0] a, input logic [15:0] d, input bit we);
    address_from_core       = a;
    data_from_core          = d;
    data_from_core_write_en = we;
    @(posedge clk);
    core_exp_q.push_back(model_read(a));
    if (!in_range(a)) err_exp = 1'b1;
    if (we) model_write(a, d);
    #1;
    data_from_core_write_en = 1'b0;
    address_from_core       = 16'h0000;
  endtask

  task automatic pulse_go();
    host_go = 1'b1;
    @(posedge clk);
    #1;
    host_go = 1'b0;
  endtask

  task automatic pulse_halt();
    host_halt = 1'b1;
    @(posedge clk);
    #1;
    host_halt = 1'b0;
  endtask

  task automatic drain_host();
    int n;
    n = 0;
    host_rsp_ready = 1'b1;
    while (host_exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("host_queue_drained", 16'(host_exp_q.size()), 16'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] a;
    reset                   = 1'b0;
    address_from_core       = 16'h0000;
    data_from_core          = 16'h0000;
    data_from_core_write_en = 1'b0;
    host_req_valid          = 1'b0;
    host_req_write          = 1'b0;
    host_req_addr           = 16'h0000;
    host_req_wdata          = 16'h0000;
    host_rsp_ready          = 1'b0;
    host_go                 = 1'b0;
    host_halt               = 1'b0;
    err_exp                 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {15'd0, host_req_ready}, 16'd0);
    check("rst_core_hold", {15'd0, core_hold}, 16'd1);
    reset = 1'b1;
    #1;
    check("rel_req_ready", {15'd0, host_req_ready}, 16'd1);
    check("rel_core_hold", {15'd0, core_hold}, 16'd1);
    check("rel_data_to_core", data_to_core, 16'h0000);
    check("rel_addr_error", {15'd0, addr_error}, 16'd0);
    check("rel_rsp_valid", {15'd0, host_rsp_valid}, 16'd0);
    check("rel_rsp_data", host_rsp_data, 16'h0000);
    @(posedge clk);
    #1;

    // Preload every word so the model is fully known.
    for (int i = 0; i < DEPTH; i++) host_req(1'b1, 16'(i), 16'($urandom));

    // Write 0xBEEF, read back with the response stalled for 3 cycles.
    host_req(1'b1, 16'h0005, 16'hBEEF);
    host_rsp_ready = 1'b0;
    host_req(1'b0, 16'h0005, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {15'd0, host_rsp_valid}, 16'd1);
      check("stall_rsp_data", host_rsp_data, 16'hBEEF);
      check("stall_req_ready", {15'd0, host_req_ready}, 16'd0);
    end
    @(posedge clk);
    #1;
    host_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    host_rsp_ready = 1'b0;
    check("rsp_retired", {15'd0, host_rsp_valid}, 16'd0);

    // Start the core.
    pulse_go();
    @(negedge clk);
    check("run_core_hold", {15'd0, core_hold}, 16'd0);
    @(posedge clk);
    #1;
    core_cycle(16'h0010, 16'h1234, 1'b1);
    core_cycle(16'h0010, 16'h0000, 1'b0);   // returns 0x1234
    core_cycle(16'h0010, 16'h5678, 1'b1);   // read-before-write: 0x1234
    core_cycle(16'h0010, 16'h0000, 1'b0);   // returns 0x5678
    core_cycle(16'h0400, 16'h0000, 1'b0);   // out of range: 0
    @(negedge clk);
    check("oor_addr_error", {15'd0, addr_error}, {15'd0, err_exp});
    @(posedge clk);
    #1;
    core_cycle(16'h0400, 16'hAAAA, 1'b1);   // dropped
    core_cycle(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("oor_sticky", {15'd0, addr_error}, 16'd1);
    @(posedge clk);
    #1;

    // Random core traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) a = 16'($urandom_range(DEPTH, 65535));
      else a = 16'($urandom_range(0, DEPTH - 1));
      core_cycle(a, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Host request during RUN is held off; accepted right after halt.
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("run_req_ready", {15'd0, host_req_ready}, 16'd0);
    end
    @(posedge clk);
    #1;
    host_halt = 1'b1;
    core_cycle(16'h0020, 16'h9999, 1'b1);   // completes in the halt cycle
    host_halt = 1'b0;
    @(negedge clk);
    check("halt_req_ready", {15'd0, host_req_ready}, 16'd1);
    check("halt_core_hold", {15'd0, core_hold}, 16'd1);
    if (host_req_ready) host_exp_q.push_back(model_read(16'h0010));
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
    pulse_go();                              // dropped: response pending
    @(negedge clk);
    check("go_dropped_hold", {15'd0, core_hold}, 16'd1);
    check("go_dropped_pending", {15'd0, host_rsp_valid}, 16'd1);
    @(posedge clk);
    #1;
    drain_host();
    host_rsp_ready = 1'b0;

    // Random host traffic in HOLD with random back-pressure.
    rsp_rand = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(DEPTH, 65535));
      else a = 16'($urandom_range(0, DEPTH - 1));
      host_req(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    rsp_rand = 1'b0;
    @(posedge clk);
    #1;
    drain_host();
    host_rsp_ready = 1'b0;

    // Request accepted in the go cycle completes while the core runs.
    host_read_with_go(16'h0020);
    core_cycle(16'($urandom_range(0, DEPTH - 1)), 16'h0000, 1'b0);
    core_cycle(16'($urandom_range(0, DEPTH - 1)), 16'h0000, 1'b0);
    @(negedge clk);
    check("run_rsp_pending", {15'd0, host_rsp_valid}, 16'd1);
    check("run_go_core_hold", {15'd0, core_hold}, 16'd0);
    @(posedge clk);
    #1;
    host_rsp_ready = 1'b1;
    core_cycle(16'($urandom_range(0, DEPTH - 1)), 16'h0000, 1'b0);
    host_rsp_ready = 1'b0;
    check("run_rsp_queue", 16'(host_exp_q.size()), 16'd0);
    check("run_addr_error", {15'd0, addr_error}, {15'd0, err_exp});

    // Reset mid-RUN with a pending host read.
    pulse_halt();
    host_read_with_go(16'h0005);
    core_cycle(16'h0030, 16'h4321, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_core_hold", {15'd0, core_hold}, 16'd1);
    check("midrst_rsp_valid", {15'd0, host_rsp_valid}, 16'd0);
    check("midrst_req_ready", {15'd0, host_req_ready}, 16'd0);
    host_exp_q.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rel2_addr_error", {15'd0, addr_error}, 16'd0);
    check("rel2_data_to_core", data_to_core, 16'h0000);
    check("rel2_req_ready", {15'd0, host_req_ready}, 16'd1);

    // RAM survives reset.
    host_rsp_ready = 1'b1;
    host_req(1'b0, 16'h0005, 16'h0000);
    host_req(1'b0, 16'h0010, 16'h0000);
    host_req(1'b0, 16'h0020, 16'h0000);
    host_req(1'b0, 16'h0030, 16'h0000);
    host_req(1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 20; i++) host_req(1'b0, 16'($urandom_range(0, DEPTH - 1)), 16'h0000);
    drain_host();
    check("final_addr_error", {15'd0, addr_error}, 16'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
